// File: rtl/chan_scan_mux.sv
// N-channel registered selector: MANUAL picks a channel with sel, SCAN walks the
// enabled channels round-robin and samples each one after DWELL cycles.
module chan_scan_mux #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 8,
    parameter int DWELL  = 16,
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [NUM_CH*DATA_W-1:0] in,
    output logic [DATA_W-1:0]        out,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    output logic                     scan_wrap
);

    typedef enum logic [1:0] {ST_MANUAL, ST_SCAN, ST_SCAN_IDLE} state_t;

    localparam logic [SEL_W:0]   NUM_CH_EXT = (SEL_W + 1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DWELL - 1);

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [SEL_W-1:0]   cur_reg;
    logic [DATA_W-1:0]  out_reg;
    logic [SEL_W-1:0]   out_ch_reg;
    logic               out_valid_reg;
    logic               scan_wrap_reg;

    logic [DATA_W-1:0]  ch_data [NUM_CH];
    logic [SEL_W-1:0]   cur_next;
    logic [SEL_W-1:0]   first_ch;
    logic               cur_en;
    logic               sel_ok;
    logic [NUM_CH-1:0]  mask_shift;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign ch_data[gi] = in[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // First enabled channel strictly above c, wrapping; returns c if it is the only one.
    function automatic logic [SEL_W-1:0] next_set(input logic [NUM_CH-1:0] m,
                                                   input logic [SEL_W-1:0] c);
        logic [SEL_W-1:0]  r;
        logic [NUM_CH-1:0] t;
        int                idx;
        r = c;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = (int'(c) + i) % NUM_CH;
            t   = m >> idx;
            if (t[0]) r = SEL_W'(idx);
        end
        return r;
    endfunction

    always_comb begin
        cur_next   = next_set(ch_mask, cur_reg);
        first_ch   = next_set(ch_mask, LAST_CH);
        mask_shift = ch_mask >> cur_reg;
        cur_en     = mask_shift[0];
        sel_ok     = ({1'b0, sel} < NUM_CH_EXT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_MANUAL;
            cnt_reg       <= '0;
            cur_reg       <= '0;
            out_reg       <= '0;
            out_ch_reg    <= '0;
            out_valid_reg <= 1'b0;
            scan_wrap_reg <= 1'b0;
        end else if (!mode) begin
            state_reg     <= ST_MANUAL;
            cnt_reg       <= '0;
            scan_wrap_reg <= 1'b0;
            if (sel_ok) begin
                out_reg       <= ch_data[sel];
                out_ch_reg    <= sel;
                out_valid_reg <= 1'b1;
            end else begin
                out_reg       <= '0;
                out_ch_reg    <= '0;
                out_valid_reg <= 1'b0;
            end
        end else begin
            out_valid_reg <= 1'b0;
            scan_wrap_reg <= 1'b0;
            case (state_reg)
                ST_SCAN: begin
                    if (ch_mask == '0) begin
                        state_reg <= ST_SCAN_IDLE;
                        cnt_reg   <= '0;
                    end else if (!cur_en) begin
                        // Current channel was disabled mid-dwell: skip ahead silently.
                        cur_reg <= cur_next;
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        out_reg       <= ch_data[cur_reg];
                        out_ch_reg    <= cur_reg;
                        out_valid_reg <= 1'b1;
                        scan_wrap_reg <= (cur_next <= cur_reg);
                        cur_reg       <= cur_next;
                        cnt_reg       <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    cnt_reg <= '0;
                    if (ch_mask != '0) begin
                        state_reg <= ST_SCAN;
                        cur_reg   <= first_ch;
                    end else begin
                        state_reg <= ST_SCAN_IDLE;
                    end
                end
            endcase
        end
    end

    assign out       = out_reg;
    assign out_ch    = out_ch_reg;
    assign out_valid = out_valid_reg;
    assign scan_wrap = scan_wrap_reg;

endmodule
